// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the instruction-fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam int          ILEN  = 32;
   localparam logic [31:0] I_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous FIFO with clear, head look-ahead and occupancy
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
   import fetch_pkg::*;
#(
   parameter type T     = fetch_entry_t,
   parameter int  DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       clear_i,
   input  T                           data_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output T                           head_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T              mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full queue is only taken when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
// ============================================================================
// fetch_prefetch_unit : decoupled fetch with prefetch queue and redirect flush
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
   parameter int          QUEUE_DEPTH     = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_pc_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_pc_i,
   input  logic [31:0] imem_rsp_instr_i,
   output logic        decode_valid_o,
   input  logic        decode_ready_i,
   output logic [31:0] decode_instr_o,
   output logic [31:0] decode_pc_o,
   output logic [31:0] decode_pcplus_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
);

   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   localparam int CW = $clog2(QUEUE_DEPTH+1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [OW-1:0] outs_q, outs_d;
   logic [OW-1:0] drop_q, drop_d;

   logic          w_full, w_empty, w_push, w_pop;
   logic [CW-1:0] w_count;
   fetch_entry_t  w_rsp_entry, w_head;
   logic          w_credit, w_req_fire, w_rsp_ok;
   logic [31:0]   w_exp_rsp_pc;

   // Credit counts in-flight requests as already occupying queue slots, so a
   // response always has somewhere to land.
   assign w_credit = (outs_q < OW'(MAX_OUTSTANDING)) &&
                     ((32'(w_count) + 32'(outs_q)) < 32'(QUEUE_DEPTH));

   assign imem_req_valid_o = rst_ni && !redirect_i && w_credit;
   assign imem_req_pc_o    = fetch_pc_q;
   assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

   // Stray responses with nothing outstanding are ignored entirely.
   assign w_rsp_ok = imem_rsp_valid_i && (outs_q != '0);

   assign w_rsp_entry.pc    = imem_rsp_pc_i;
   assign w_rsp_entry.instr = imem_rsp_instr_i;

   assign w_push = w_rsp_ok && (drop_q == '0) && !redirect_i;
   assign w_pop  = decode_valid_o && decode_ready_i;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      outs_d     = outs_q + OW'(w_req_fire) - OW'(w_rsp_ok);
      drop_d     = drop_q;
      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i;
         drop_d     = outs_d;
      end else begin
         if (w_req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (w_rsp_ok && (drop_q != '0)) drop_d = drop_q - OW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_pc_q <= BOOT_ADDR;
         outs_q     <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         outs_q     <= outs_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .T     (fetch_entry_t),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .clear_i (redirect_i),
      .data_i  (w_rsp_entry),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count),
      .head_o  (w_head)
   );

   assign decode_valid_o  = !w_empty;
   assign decode_instr_o  = decode_valid_o ? w_head.instr         : I_NOP;
   assign decode_pc_o     = decode_valid_o ? w_head.pc            : BOOT_ADDR;
   assign decode_pcplus_o = decode_valid_o ? (w_head.pc + 32'd4)  : 32'd0;

   // The oldest outstanding request address, valid once all stale responses are gone.
   assign w_exp_rsp_pc = fetch_pc_q - {{(30-OW){1'b0}}, outs_q, 2'b00};

   a_outs_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      outs_q <= OW'(MAX_OUTSTANDING));
   a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_count <= CW'(QUEUE_DEPTH));
   a_drop_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      drop_q <= outs_q);
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (w_full && w_push) |-> w_pop);
   a_rsp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
      imem_rsp_valid_i |-> (outs_q != '0));
   a_rsp_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_push |-> (imem_rsp_pc_i == w_exp_rsp_pc));

endmodule

`default_nettype wire
